ram512_burst_ctrl: RTL
======================

Name: ram512_burst_ctrl

Overview:
Burst access controller that sits directly upstream of the 512-word RAM and drives its addr/in/ld port. It accepts one burst command at a time: a start address and a length. It then streams write data into consecutive RAM words, or streams consecutive RAM words out through a registered, back-pressured read port. The RAM read path is combinational on address and writes on the clock edge when ld is high.

Parameters:
DW, 16, data word width (RAM word width)
AW, 9, RAM address width (512 words)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  burst command offered
cmd_ready  output  1  controller idle, command accepted when cmd_valid&cmd_ready
cmd_write  input  1  1=write burst, 0=read burst
cmd_addr  input  AW  start word address
cmd_len  input  AW  burst length minus one (0 → 1 word, 511 → 512 words)
wr_valid  input  1  write data beat offered
wr_ready  output  1  write beat accepted when wr_valid&wr_ready
wr_data  input  DW  write data
rd_valid  output  1  rd_data holds a valid word
rd_ready  input  1  consumer takes the word when rd_valid&rd_ready
rd_data  output  DW  registered read data
ram_addr  output  AW  to RAM addr
ram_in  output  DW  to RAM in
ram_ld  output  1  to RAM ld (write enable)
ram_out  input  DW  from RAM out (combinational read of ram_addr)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse after the final beat of a burst

Behaviour:
- Clock clk; reset is synchronous and active-high, named reset.
- Reset values: state IDLE, cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=0, ram_addr=0, ram_ld=0, busy=0, done=0, counters 0.
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE: cmd_ready=1. On handshake, cur_addr<=cmd_addr and remaining<=cmd_len. Next state is WRITE if cmd_write, else READ.
- WRITE:
  - wr_ready=1; ram_addr=cur_addr; ram_in=wr_data; ram_ld=wr_valid (combinational, only in WRITE).
  - Each accepted beat: cur_addr<=cur_addr+1 mod 512.
  - If remaining==0 → IDLE with done=1 the next cycle; otherwise remaining--.
  - wr_valid low = stall; no RAM write and no address advance.
- READ:
  - ram_addr=cur_addr.
  - The output register may load when rd_valid==0 or (rd_valid&rd_ready). Load means rd_data<=ram_out, rd_valid<=1, cur_addr++ mod 512.
  - Loading the word with remaining==0 → DRAIN; otherwise remaining--.
  - Full throughput: one word per cycle while rd_ready stays high.
- DRAIN: no fetch. When rd_valid&rd_ready: rd_valid<=0 → IDLE, done=1 the next cycle.
- rd_valid, once high, holds and rd_data holds stable until the handshake.
- Latency:
  - Read: command accepted at edge N, first word loaded at edge N+1, so rd_valid is high in cycle N+1.
  - Write: first beat can be accepted in cycle N+1.
- done: registered, high only in the first IDLE cycle after a burst. A new command may be accepted in that same cycle.
- ram_ld is never high outside WRITE. Wrap-around of cur_addr is silent: 511+1=0.
- cmd_valid while busy is ignored (cmd_ready=0). wr_valid outside WRITE is ignored (wr_ready=0).
- Reset mid-burst: abort at that edge; return to IDLE; drop rd_valid; no further ram_ld; no done pulse. RAM words already written remain.

Test Plan:
- Reset, then idle → cmd_ready=1, busy=0, ram_ld=0, rd_valid=0, done=0.
- Write burst: addr=5, len=3, wr_valid held high with data 0xA000..0xA003 → ram_ld high 4 cycles at ram_addr 5,6,7,8; done pulses one cycle after beat 4; cmd_ready returns high.
- Read burst: addr=5, len=3, rd_ready=1 → rd_data 0xA000..0xA003 on 4 consecutive cycles starting cycle N+1; then done; busy low.
- Back-pressure: same read with rd_ready toggling 1,0,0,1… → rd_data stable while stalled; no word lost or duplicated; order preserved.
- Wrap: write addr=510, len=2 data 1,2,3 → writes at 510, 511, 0. Read back with addr=510, len=2 returns 1,2,3. len=511 from addr 0 → exactly 512 beats then done.
- Reset in the 2nd beat of a 4-word write → no ram_ld after reset; only the 1st word written; cmd_ready=1 next cycle; done stays 0. Repeat during a stalled read → rd_valid drops.

Source files
------------

// File: rtl/ram512_burst_ctrl.sv
// Burst access controller in front of a 512-word RAM with a combinational read.
// Write bursts stream beats straight into the RAM; read bursts go through a registered, back-pressured output.
module ram512_burst_ctrl #(
   parameter int DW = 16,
   parameter int AW = 9
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [AW-1:0] cmd_len,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [DW-1:0] wr_data,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [DW-1:0] rd_data,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_in,
   output logic          ram_ld,
   input  logic [DW-1:0] ram_out,
   output logic          busy,
   output logic          done
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WRITE = 2'd1;
   localparam logic [1:0] READ  = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   logic [1:0]    state;
   logic [AW-1:0] cur_addr;
   logic [AW-1:0] remaining;
   logic          wr_beat;
   logic          rd_load;
   logic          rd_take;

   assign cmd_ready = (state == IDLE);
   assign wr_ready  = (state == WRITE);
   assign busy      = (state != IDLE);
   assign ram_addr  = cur_addr;
   assign ram_in    = wr_data;

   // Reset gates the write strobe so a burst aborted by reset commits nothing at that edge.
   assign wr_beat = (state == WRITE) && wr_valid;
   assign ram_ld  = wr_beat && !reset;

   assign rd_take = rd_valid && rd_ready;
   assign rd_load = (state == READ) && (!rd_valid || rd_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cur_addr  <= '0;
         remaining <= '0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  cur_addr  <= cmd_addr;
                  remaining <= cmd_len;
                  state     <= cmd_write ? WRITE : READ;
               end
            end
            WRITE: begin
               if (wr_beat) begin
                  cur_addr <= cur_addr + 1'b1;
                  if (remaining == '0) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end else begin
                     remaining <= remaining - 1'b1;
                  end
               end
            end
            READ: begin
               // A fetch either fills an empty register or replaces the word being taken this cycle.
               if (rd_load) begin
                  rd_data  <= ram_out;
                  rd_valid <= 1'b1;
                  cur_addr <= cur_addr + 1'b1;
                  if (remaining == '0) begin
                     state <= DRAIN;
                  end else begin
                     remaining <= remaining - 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (rd_take) begin
                  rd_valid <= 1'b0;
                  state    <= IDLE;
                  done     <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
